// File: rtl/led_pkg.sv
// Project-wide LED/PWM constants shared by the LED driver top level and its PWM channels.
package led_pkg;

    localparam int unsigned PWM_S_CNT      = 200;
    localparam int unsigned PWM_CNT_W      = 8;
    localparam int unsigned LED_CNT        = 18;
    localparam int unsigned MAX_BRIGHTNESS = 200;

endpackage : led_pkg

// File: rtl/pwm_channel_if.sv
// Duty request in, PWM waveform and period marker out, for one PWM channel.
interface pwm_channel_if
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_CNT_W
) ();

    logic [WIDTH-1:0] on_time;
    logic             out;
    logic             period_start;

    modport master (
        output on_time,
        input  out,
        input  period_start
    );

    modport slave (
        input  on_time,
        output out,
        output period_start
    );

endinterface : pwm_channel_if

// File: rtl/pwm_channel.sv
// Single-channel PWM generator: high for the first on_time samples of each PERIOD-sample period,
// with the duty latched only at the period wrap.
module pwm_channel
    import led_pkg::*;
#(
    parameter int unsigned WIDTH  = PWM_CNT_W,
    parameter int unsigned PERIOD = PWM_S_CNT
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_channel_if.slave bus
);

    localparam logic [WIDTH-1:0] LP_LAST      = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] LP_CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] LP_CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    // One extra duty bit keeps PERIOD itself representable when PERIOD == 2**WIDTH.
    localparam logic [WIDTH:0]   LP_PERIOD    = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0]   LP_DUTY_ZERO = {(WIDTH+1){1'b0}};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH:0]   r_duty;
    logic             r_out;
    logic             r_start;

    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH:0]   w_duty_nxt;
    logic             w_out_nxt;
    logic             w_start_nxt;

    function automatic logic [WIDTH:0] clamp_duty(input logic [WIDTH-1:0] req);
        logic [WIDTH:0] w_req;
        w_req = {1'b0, req};
        if (w_req >= LP_PERIOD) begin
            clamp_duty = LP_PERIOD;
        end else begin
            clamp_duty = w_req;
        end
    endfunction

    // Next counter/duty state; outputs are decoded from these so the flops show the new sample.
    always_comb begin
        w_wrap      = (r_cnt == LP_LAST);
        w_cnt_nxt   = r_cnt;
        w_duty_nxt  = r_duty;
        if (w_wrap) begin
            w_cnt_nxt  = LP_CNT_ZERO;
            w_duty_nxt = clamp_duty(bus.on_time);
        end else begin
            w_cnt_nxt  = r_cnt + LP_CNT_ONE;
            w_duty_nxt = r_duty;
        end
        w_out_nxt   = ({1'b0, w_cnt_nxt} < w_duty_nxt);
        w_start_nxt = (w_cnt_nxt == LP_CNT_ZERO);
    end

    // Counter, latched duty and registered waveform outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= LP_LAST;
            r_duty  <= LP_DUTY_ZERO;
            r_out   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_out   <= w_out_nxt;
            r_start <= w_start_nxt;
        end
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_start;

endmodule : pwm_channel

// File: tb/tb_pwm_channel.sv
// Scoreboard bench for pwm_channel: each period's expected waveform is queued when its duty is applied.
module tb_pwm_channel;
    import led_pkg::*;

    localparam int W = PWM_CNT_W;
    localparam int P = PWM_S_CNT;

    typedef struct {
        logic out;
        logic ps;
        bit   last;
        int   hi;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_channel_if #(.WIDTH(W)) pif ();

    pwm_channel #(.WIDTH(W), .PERIOD(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;
    int   hi_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected samples of one period: the first min(d, P) are high, sample 0 carries the marker.
    task automatic push_period(input int d, input int n);
        exp_t e;
        int   eff;
        eff = (d > P) ? P : d;
        for (int k = 0; k < n; k++) begin
            e.out  = (k < eff);
            e.ps   = (k == 0);
            e.last = (k == P - 1);
            e.hi   = eff;
            q.push_back(e);
        end
    endtask

    // Called at the negedge before a wrap edge; returns at the negedge before the following wrap.
    task automatic run_period(input int d, input int glitch_at, input int glitch_val);
        pif.on_time = W'(d);
        push_period(d, P);
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            if (k == glitch_at) pif.on_time = W'(glitch_val);
        end
    endtask

    // Monitor: compare every presented sample against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                check("out", int'(pif.out), int'(e.out));
                check("period_start", int'(pif.period_start), int'(e.ps));
                hi_cnt = e.ps ? int'(pif.out) : hi_cnt + int'(pif.out);
                if (e.last) check("high_count", hi_cnt, e.hi);
            end
        end
    end

    initial begin
        int d;
        int g;
        pif.on_time = W'(123);
        repeat (3) @(negedge clk);
        check("reset_out", int'(pif.out), 0);
        check("reset_period_start", int'(pif.period_start), 0);

        // Release; the very next edge must start a period with on_time loaded.
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) run_period(0, -1, 0);
        repeat (3) run_period(200, -1, 0);
        repeat (3) run_period(255, -1, 0);
        repeat (4) run_period(50, -1, 0);

        // Mid-period change only takes effect after the next wrap.
        run_period(50, 20, 150);
        run_period(150, -1, 0);

        // Reset at cnt==30 must drop outputs without a clock edge.
        pif.on_time = W'(100);
        push_period(100, 31);
        repeat (31) @(negedge clk);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", int'(pif.out), 0);
        check("async_reset_period_start", int'(pif.period_start), 0);
        check("scoreboard_drained_at_reset", q.size(), 0);
        repeat (2) @(negedge clk);
        check("held_reset_out", int'(pif.out), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_period(100, -1, 0);

        repeat (2) run_period(1, -1, 0);
        repeat (2) run_period(199, -1, 0);

        // Random duties with random mid-period disturbances.
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 255);
            g = ($urandom_range(0, 1) == 1) ? $urandom_range(0, P - 2) : -1;
            run_period(d, g, $urandom_range(0, 255));
        end

        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pwm_channel
